ref_seq_reader: RTL
===================

Name: ref_seq_reader

Overview:
- DRAM-side reference reader for one Smith-Waterman engine.
- Accepts a reference request (start address, length in blocks) from the engine controller and issues sequential DRAM read requests.
- Buffers the returned words in an internal FIFO and streams them to the engine as reference sequence blocks over a valid/rdy handshake.
- Sits between the engine's reference-info/reference-block ports and the shared DRAM read port.

Parameters:
- REF_LENGTH, 128, bases per reference block; block width is 2*REF_LENGTH bits.
- FIFO_DEPTH, 8, return-buffer depth in blocks; power of 2, minimum 2.
- ADDR_STRIDE, 1, DRAM address increment per block.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ref_addr_in  in  25  DRAM start address of the reference
- ref_length_in  in  25  number of blocks to read
- ref_info_valid_in  in  1  single-cycle request strobe; there is no ready handshake
- ref_seq_block_out  out  2*REF_LENGTH  reference block to engine
- ref_seq_block_valid_out  out  1  block valid
- ref_seq_block_rdy_in  in  1  engine accepts block
- dram_rd_addr_out  out  25  DRAM read address
- dram_rd_req_out  out  1  read request
- dram_rd_ack_in  in  1  DRAM accepted request this cycle
- dram_rd_data_in  in  2*REF_LENGTH  read return data, in request order
- dram_rd_data_valid_in  in  1  return valid; cannot be backpressured
- busy_out  out  1  request in progress or pending
- req_overflow_out  out  1  sticky: request dropped

Behaviour:
- Reset: all outputs 0. State IDLE, FIFO empty, all counters 0, pending slot empty. Reset asserted mid-operation aborts immediately; DRAM returns arriving after reset deassertion for pre-reset requests are not tracked (system resets DRAM side together).
- Request capture:
  - ref_info_valid_in in IDLE with no pending request: load addr/length, go to ISSUE next cycle.
  - Strobe while busy: store in the one-deep pending slot.
  - Strobe while the pending slot is full: dropped; req_overflow_out set, cleared only by rst.
  - On return to IDLE with the pending slot full: start the pending request the next cycle.
- States:
  - IDLE:
    - Length 0 request: no DRAM reads, no output, stays IDLE (busy_out high for 1 cycle).
    - Otherwise go to ISSUE.
  - ISSUE:
    - dram_rd_req_out is high when outstanding + fifo_count < FIFO_DEPTH.
    - outstanding = acked reads not yet returned.
    - dram_rd_addr_out = start + n*ADDR_STRIDE, where n = reads acked so far.
    - req/addr are held stable until ack.
    - On the ack of the last read (n = length-1), drop req in the following cycle and go to DRAIN.
  - DRAIN: when all length blocks have been handed to the engine, go to IDLE.
- Credit rule: guarantees a return always has a free FIFO slot. A return into a full FIFO is a design error; the bench asserts it never occurs.
- Counting:
  - Returning data and FIFO pop in the same cycle: fifo_count unchanged.
  - Ack and return in the same cycle: outstanding unchanged.
- FIFO output:
  - First-word-fall-through.
  - A return in cycle t is visible with valid=1 in cycle t+1.
  - ref_seq_block_out and ref_seq_block_valid_out are held stable while valid & !rdy.
  - Pop on valid & rdy.
- Widths:
  - Address adds wrap modulo 2^25.
  - Internal block counters are 25 bits.
  - busy_out = (state != IDLE) | pending.

Test Plan:
- Basic: addr=0x100, len=3; DRAM acks every cycle with 2-cycle latency; engine rdy=1 -> reads at 0x100, 0x101, 0x102, three blocks delivered in order, busy_out drops after the third handshake.
- Backpressure: len=20, FIFO_DEPTH=8, engine rdy=0 -> exactly 8 reads acked, then req held low. Raise rdy -> remaining 12 reads issue, 20 blocks delivered intact, no FIFO overflow.
- Zero length, then normal: len=0 then len=1 at 0x1FFFFFF -> no reads for the first request; one read at 0x1FFFFFF for the second. len=2 from 0x1FFFFFF reads 0x1FFFFFF then 0x0000000.
- Pending/overflow: issue A (len=4), then B and C strobes during A -> B is executed after A with no idle read gap beyond one cycle; C dropped; req_overflow_out=1 until rst.
- DRAM stall: dram_rd_ack_in low for 5 cycles -> dram_rd_addr_out and dram_rd_req_out held stable; stride test with ADDR_STRIDE=4 gives addresses 0x10, 0x14, 0x18.
- Reset mid-transfer: assert rst during ISSUE of len=10 -> all outputs 0 asynchronously. After release, a new request (addr=0x40, len=2) completes normally.

Source files
------------

// File: rtl/ref_seq_reader_if.sv
// rtl/ref_seq_reader_if.sv - request, block-stream and DRAM read signals of the reference reader
interface ref_seq_reader_if #(
    parameter int REF_LENGTH = 128
);
    logic [24:0]             ref_addr_in;
    logic [24:0]             ref_length_in;
    logic                    ref_info_valid_in;
    logic [2*REF_LENGTH-1:0] ref_seq_block_out;
    logic                    ref_seq_block_valid_out;
    logic                    ref_seq_block_rdy_in;
    logic [24:0]             dram_rd_addr_out;
    logic                    dram_rd_req_out;
    logic                    dram_rd_ack_in;
    logic [2*REF_LENGTH-1:0] dram_rd_data_in;
    logic                    dram_rd_data_valid_in;
    logic                    busy_out;
    logic                    req_overflow_out;

    // The reader masters the DRAM read port and the block stream.
    modport master (
        input  ref_addr_in, ref_length_in, ref_info_valid_in, ref_seq_block_rdy_in,
               dram_rd_ack_in, dram_rd_data_in, dram_rd_data_valid_in,
        output ref_seq_block_out, ref_seq_block_valid_out, dram_rd_addr_out,
               dram_rd_req_out, busy_out, req_overflow_out
    );

    modport slave (
        output ref_addr_in, ref_length_in, ref_info_valid_in, ref_seq_block_rdy_in,
               dram_rd_ack_in, dram_rd_data_in, dram_rd_data_valid_in,
        input  ref_seq_block_out, ref_seq_block_valid_out, dram_rd_addr_out,
               dram_rd_req_out, busy_out, req_overflow_out
    );
endinterface

// File: rtl/ref_seq_reader.sv
// rtl/ref_seq_reader.sv - sequential DRAM reference reader with credit-limited return FIFO
module ref_seq_reader #(
    parameter int REF_LENGTH  = 128,
    parameter int FIFO_DEPTH  = 8,
    parameter int ADDR_STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst,
    ref_seq_reader_if.master bus
);
    localparam int              BW        = 2 * REF_LENGTH;
    localparam int              PW        = $clog2(FIFO_DEPTH);
    localparam int              CW        = PW + 1;
    localparam logic [24:0]     STRIDE    = 25'(ADDR_STRIDE);
    localparam logic [CW:0]     DEPTH_LIM = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]   ONE_C     = CW'(1);
    localparam logic [PW-1:0]   ONE_P     = PW'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [24:0]     addr_q, addr_d;
    logic [24:0]     len_q, len_d;
    logic [24:0]     issued_q, issued_d;
    logic [24:0]     delivered_q, delivered_d;
    logic [24:0]     pend_addr_q, pend_addr_d;
    logic [24:0]     pend_len_q, pend_len_d;
    logic            pend_valid_q, pend_valid_d;
    logic            overflow_q, overflow_d;
    logic            zero_q, zero_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [BW-1:0]   mem_q [FIFO_DEPTH];

    logic            req;
    logic            ack_fire;
    logic            ret;
    logic            pop;
    logic            blk_valid;
    logic            launch_pend;
    logic            launch_new;
    logic [24:0]     launch_addr;
    logic [24:0]     launch_len;

    // Credit rule: only ask for a read while every in-flight word already has a FIFO slot.
    assign req       = (state_q == ISSUE) &&
                       (({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_LIM);
    assign ack_fire  = req && bus.dram_rd_ack_in;
    // Returns with nothing outstanding belong to requests issued before a reset.
    assign ret       = bus.dram_rd_data_valid_in && (outstanding_q != '0);
    assign blk_valid = (count_q != '0);
    assign pop       = blk_valid && bus.ref_seq_block_rdy_in;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        issued_d     = issued_q;
        delivered_d  = delivered_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_len_d   = pend_len_q;
        overflow_d   = overflow_q;
        zero_d       = 1'b0;

        launch_pend = (state_q == IDLE) && pend_valid_q;
        launch_new  = (state_q == IDLE) && !pend_valid_q && bus.ref_info_valid_in;
        launch_addr = launch_pend ? pend_addr_q : bus.ref_addr_in;
        launch_len  = launch_pend ? pend_len_q  : bus.ref_length_in;

        if (launch_pend || launch_new) begin
            addr_d      = launch_addr;
            len_d       = launch_len;
            issued_d    = '0;
            delivered_d = '0;
            if (launch_len == '0) begin
                zero_d = 1'b1;
            end else begin
                state_d = ISSUE;
            end
        end

        if (launch_pend) begin
            pend_valid_d = 1'b0;
        end

        // A strobe that is not launched directly goes to the slot, which frees up when it launches.
        if (bus.ref_info_valid_in && !launch_new) begin
            if (pend_valid_q && !launch_pend) begin
                overflow_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_addr_d  = bus.ref_addr_in;
                pend_len_d   = bus.ref_length_in;
            end
        end

        if (pop) begin
            delivered_d = delivered_q + 25'd1;
        end

        case (state_q)
            ISSUE: begin
                if (ack_fire) begin
                    addr_d   = addr_q + STRIDE;
                    issued_d = issued_q + 25'd1;
                    if (issued_q == len_q - 25'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (delivered_d == len_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        count_d       = count_q;
        outstanding_d = outstanding_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (ret) begin
            wr_ptr_d = wr_ptr_q + ONE_P;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE_P;
        end

        if (ret && !pop) begin
            count_d = count_q + ONE_C;
        end else if (!ret && pop) begin
            count_d = count_q - ONE_C;
        end

        if (ack_fire && !ret) begin
            outstanding_d = outstanding_q + ONE_C;
        end else if (!ack_fire && ret) begin
            outstanding_d = outstanding_q - ONE_C;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            delivered_q   <= '0;
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            pend_len_q    <= '0;
            overflow_q    <= 1'b0;
            zero_q        <= 1'b0;
            outstanding_q <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            len_q         <= len_d;
            issued_q      <= issued_d;
            delivered_q   <= delivered_d;
            pend_valid_q  <= pend_valid_d;
            pend_addr_q   <= pend_addr_d;
            pend_len_q    <= pend_len_d;
            overflow_q    <= overflow_d;
            zero_q        <= zero_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the read side is masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (ret) begin
            mem_q[wr_ptr_q] <= bus.dram_rd_data_in;
        end
    end

    assign bus.dram_rd_req_out         = req;
    assign bus.dram_rd_addr_out        = addr_q;
    assign bus.ref_seq_block_valid_out = blk_valid;
    assign bus.ref_seq_block_out       = blk_valid ? mem_q[rd_ptr_q] : '0;
    assign bus.busy_out                = (state_q != IDLE) || pend_valid_q || zero_q;
    assign bus.req_overflow_out        = overflow_q;
endmodule
